// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, write-back select codes and register-file constants
package mips_pkg;
    localparam int B_DEF = 32;
    localparam int W_DEF = 5;
    localparam int ZERO_REG = 0;
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSV  = 2'b11
    } wb_sel_e;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: 3:1 write-back source select, reserved code yields zero
module wb_mux
    import mips_pkg::*;
#(
    parameter int B = B_DEF
) (
    input  logic [1:0]   i_sel,
    input  logic [B-1:0] i_alu,
    input  logic [B-1:0] i_mem,
    input  logic [B-1:0] i_link,
    output logic [B-1:0] o_data
);
    // pick the write-back source; the unused encoding drives zero
    always_comb begin
        o_data = (i_sel == WB_SEL_ALU)  ? i_alu  :
                 (i_sel == WB_SEL_MEM)  ? i_mem  :
                 (i_sel == WB_SEL_LINK) ? i_link : '0;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back select and forwarding source (optional RETIRE_COUNT_EN adds retire_count)
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [B-1:0] mem_data_in,
    input  logic [B-1:0] alu_result_in,
    input  logic [B-1:0] link_addr_in,
    input  logic [W-1:0] rd_in,
    input  logic         reg_write_in,
    input  logic [1:0]   wb_sel_in,
    output logic         valid_out,
    output logic         reg_write_out,
    output logic [W-1:0] rd_out,
    output logic [B-1:0] wb_data_out,
    output logic         fwd_valid,
    output logic [W-1:0] fwd_rd,
    output logic [B-1:0] fwd_data
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0]  retire_count
`endif
);
    logic         r_valid;
    logic         r_reg_write;
    logic [W-1:0] r_rd;
    logic [B-1:0] r_mem;
    logic [B-1:0] r_alu;
    logic [B-1:0] r_link;
    logic [1:0]   r_sel;
    logic [B-1:0] w_wb_data;
    logic         w_write;

    // reset and flush both empty the stage; stall holds; otherwise capture
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_mem       <= '0;
            r_alu       <= '0;
            r_link      <= '0;
            r_sel       <= 2'b00;
        end else if (!stall) begin
            r_valid     <= valid_in;
            r_reg_write <= reg_write_in;
            r_rd        <= rd_in;
            r_mem       <= mem_data_in;
            r_alu       <= alu_result_in;
            r_link      <= link_addr_in;
            r_sel       <= wb_sel_in;
        end
    end

    wb_mux #(.B(B)) u_wb_mux (
        .i_sel  (r_sel),
        .i_alu  (r_alu),
        .i_mem  (r_mem),
        .i_link (r_link),
        .o_data (w_wb_data)
    );

    assign w_write       = r_reg_write & r_valid & (r_rd != W'(ZERO_REG));
    assign valid_out     = r_valid;
    assign reg_write_out = w_write;
    assign rd_out        = r_rd;
    assign wb_data_out   = w_wb_data;
    assign fwd_valid     = w_write;
    assign fwd_rd        = r_rd;
    assign fwd_data      = w_wb_data;

`ifdef RETIRE_COUNT_EN
    logic [31:0] r_retire_count;

    // count each instruction once as it leaves WB; wraps silently
    always_ff @(posedge clk) begin
        if (reset)
            r_retire_count <= '0;
        else if (r_valid && !stall)
            r_retire_count <= r_retire_count + 32'd1;
    end

    assign retire_count = r_retire_count;
`endif
endmodule
